pmem_loader: RTL and testbench

//  Writer side of the program-memory port: fetch only reads PMEM, this block fills it.

---
 rtl/pmem_loader_pkg.sv | 19 +
 rtl/pmem_loader.sv | 175 +++++++++++++++++
 tb/tb_pmem_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_loader_pkg.sv
// Shared definitions for the program-memory loader.
//   LOADER_HDR      : frame header byte
//   loader_state_e  : loader FSM state encoding (3 bits)
package pmem_loader_pkg;

   localparam logic [7:0] LOADER_HDR = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_HI  = 3'd1,
      ST_LEN_LO  = 3'd2,
      ST_DATA_HI = 3'd3,
      ST_DATA_LO = 3'd4,
      ST_CHECK   = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERROR   = 3'd7
   } loader_state_e;

endpackage

// File: rtl/pmem_loader.sv
// pmem_loader: writer side of the program-memory port.
// Accepts a framed byte stream (A5, LEN_HI, LEN_LO, LEN x {HI,LO}, CHK),
// packs byte pairs into words and writes them to PMEM through a dedicated
// write port. The core is held stopped until a frame passes its checksum.
// Integration: core reset = reset & out_core_run.
// Ports:
//   clock, reset          clock (rising edge), async active-low reset
//   in_byte/_valid        stream byte and its valid
//   out_byte_ready        loader accepts a byte (transfer = valid & ready)
//   out_pmem_addr/_word   PMEM write address (bytes) and data
//   out_pmem_write_en     one-cycle write strobe
//   out_words_loaded      words written in the current frame
//   out_busy              frame in progress
//   out_core_run          1 = core may run
//   out_error             sticky frame error
module pmem_loader
   import pmem_loader_pkg::*;
#(
   parameter int unsigned PMEM_ADDR_WIDTH = 12,
   parameter int unsigned PMEM_WORD_WIDTH = 16,
   parameter int unsigned PMEM_NUM_WORDS  = 2048,
   parameter int unsigned PC_INCREMENT    = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [7:0]                 in_byte,
   input  logic                       in_byte_valid,
   output logic                       out_byte_ready,
   output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
   output logic [PMEM_WORD_WIDTH-1:0] out_pmem_word,
   output logic                       out_pmem_write_en,
   output logic [PMEM_ADDR_WIDTH-1:0] out_words_loaded,
   output logic                       out_busy,
   output logic                       out_core_run,
   output logic                       out_error
);

   loader_state_e              state_q, state_d;
   logic                       ready_q, ready_d;
   logic [7:0]                 len_hi_q, len_hi_d;
   logic [15:0]                len_q, len_d;
   logic [7:0]                 hi_q, hi_d;
   logic [7:0]                 xor_q, xor_d;
   logic [PMEM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [PMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [PMEM_WORD_WIDTH-1:0] word_q, word_d;
   logic                       we_q, we_d;
   logic                       run_q, run_d;
   logic                       err_q, err_d;

   logic                       xfer;
   logic [15:0]                len_next;

   assign xfer     = in_byte_valid & ready_q;
   assign len_next = {len_hi_q, in_byte};

   always_comb begin
      state_d  = state_q;
      ready_d  = 1'b1;
      len_hi_d = len_hi_q;
      len_d    = len_q;
      hi_d     = hi_q;
      xor_d    = xor_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      word_d   = word_q;
      we_d     = 1'b0;
      run_d    = run_q;
      err_d    = err_q;

      if (xfer) begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_byte == LOADER_HDR) begin
                  state_d = ST_LEN_HI;
                  xor_d   = '0;
                  cnt_d   = '0;
               end
            end
            ST_LEN_HI: begin
               len_hi_d = in_byte;
               xor_d    = xor_q ^ in_byte;
               state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d = len_next;
               xor_d = xor_q ^ in_byte;
               if (len_next > 16'(PMEM_NUM_WORDS)) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else if (len_next == '0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               hi_d    = in_byte;
               xor_d   = xor_q ^ in_byte;
               state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               // Write is registered: strobe, address and count all appear
               // together on the cycle after the low byte.
               xor_d  = xor_q ^ in_byte;
               we_d   = 1'b1;
               addr_d = PMEM_ADDR_WIDTH'(cnt_q * PC_INCREMENT);
               word_d = {hi_q, in_byte};
               cnt_d  = cnt_q + 1'b1;
               if (16'(cnt_q) + 16'd1 == len_q) state_d = ST_CHECK;
               else                             state_d = ST_DATA_HI;
            end
            ST_CHECK: begin
               if (in_byte == xor_q) begin
                  state_d = ST_DONE;
                  run_d   = 1'b1;
               end else begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end
            end
            ST_DONE, ST_ERROR: begin
               if (in_byte == LOADER_HDR) begin
                  state_d = ST_LEN_HI;
                  run_d   = 1'b0;
                  err_d   = 1'b0;
                  xor_d   = '0;
                  cnt_d   = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b0;
         len_hi_q <= '0;
         len_q    <= '0;
         hi_q     <= '0;
         xor_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         word_q   <= '0;
         we_q     <= 1'b0;
         run_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         len_hi_q <= len_hi_d;
         len_q    <= len_d;
         hi_q     <= hi_d;
         xor_q    <= xor_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         word_q   <= word_d;
         we_q     <= we_d;
         run_q    <= run_d;
         err_q    <= err_d;
      end
   end

   assign out_byte_ready    = ready_q;
   assign out_pmem_addr     = addr_q;
   assign out_pmem_word     = word_q;
   assign out_pmem_write_en = we_q;
   assign out_words_loaded  = cnt_q;
   assign out_busy          = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign out_core_run      = run_q;
   assign out_error         = err_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Directed testbench for pmem_loader.
module tb_pmem_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_byte_valid = 1'b0;
   logic        out_byte_ready;
   logic [11:0] out_pmem_addr;
   logic [15:0] out_pmem_word;
   logic        out_pmem_write_en;
   logic [11:0] out_words_loaded;
   logic        out_busy;
   logic        out_core_run;
   logic        out_error;

   int checks = 0;
   int errors = 0;

   logic [11:0] mon_addr[$];
   logic [15:0] mon_word[$];
   logic [7:0]  stream[$];

   pmem_loader #(
      .PMEM_ADDR_WIDTH(12),
      .PMEM_WORD_WIDTH(16),
      .PMEM_NUM_WORDS (2048),
      .PC_INCREMENT   (2)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .in_byte          (in_byte),
      .in_byte_valid    (in_byte_valid),
      .out_byte_ready   (out_byte_ready),
      .out_pmem_addr    (out_pmem_addr),
      .out_pmem_word    (out_pmem_word),
      .out_pmem_write_en(out_pmem_write_en),
      .out_words_loaded (out_words_loaded),
      .out_busy         (out_busy),
      .out_core_run     (out_core_run),
      .out_error        (out_error)
   );

   always #5 clock = ~clock;

   // Capture every write strobe away from the active edge.
   always @(negedge clock) begin
      if (out_pmem_write_en === 1'b1) begin
         mon_addr.push_back(out_pmem_addr);
         mon_word.push_back(out_pmem_word);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One byte per call; consecutive calls give back-to-back transfers.
   task automatic send_byte(input logic [7:0] b);
      in_byte       = b;
      in_byte_valid = 1'b1;
      @(posedge clock);
      #1;
      in_byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_byte_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({out_byte_ready, out_pmem_write_en, out_busy, out_core_run, out_error} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {out_byte_ready, out_pmem_write_en, out_busy, out_core_run, out_error});
      end
      checks++;
      if ({out_pmem_addr, out_pmem_word, out_words_loaded} !== 40'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0",
                  {out_pmem_addr, out_pmem_word, out_words_loaded});
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (out_byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_clock: got %b expected 0", out_byte_ready);
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_byte_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_clock: got %b expected 1", out_byte_ready);
      end
   endtask

   // A5 00 02 12 34 AB CD, checksum 02^12^34^AB^CD = 0x42
   task automatic test_good_frame();
      mon_addr.delete(); mon_word.delete();
      send_byte(8'hA5);
      checks++;
      if (out_busy !== 1'b1) begin
         errors++; $display("FAIL busy_after_hdr: got %b expected 1", out_busy);
      end
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
      checks++;
      if (out_pmem_write_en !== 1'b0) begin
         errors++; $display("FAIL we_after_hi: got %b expected 0", out_pmem_write_en);
      end
      send_byte(8'h34);
      checks++;
      if ({out_pmem_write_en, out_pmem_addr, out_pmem_word, out_words_loaded} !== {1'b1, 12'h000, 16'h1234, 12'd1}) begin
         errors++;
         $display("FAIL write0: got we=%b addr=%h word=%h loaded=%0d expected we=1 addr=000 word=1234 loaded=1",
                  out_pmem_write_en, out_pmem_addr, out_pmem_word, out_words_loaded);
      end
      send_byte(8'hAB);
      checks++;
      if (out_pmem_write_en !== 1'b0) begin
         errors++; $display("FAIL we_single_cycle: got %b expected 0", out_pmem_write_en);
      end
      send_byte(8'hCD);
      checks++;
      if ({out_pmem_write_en, out_pmem_addr, out_pmem_word, out_words_loaded} !== {1'b1, 12'h002, 16'hABCD, 12'd2}) begin
         errors++;
         $display("FAIL write1: got we=%b addr=%h word=%h loaded=%0d expected we=1 addr=002 word=abcd loaded=2",
                  out_pmem_write_en, out_pmem_addr, out_pmem_word, out_words_loaded);
      end
      checks++;
      if (out_core_run !== 1'b0) begin
         errors++; $display("FAIL run_before_chk: got %b expected 0", out_core_run);
      end
      send_byte(8'h42);
      checks++;
      if ({out_core_run, out_error, out_busy} !== 3'b100) begin
         errors++;
         $display("FAIL good_done: got run/err/busy=%b expected 100", {out_core_run, out_error, out_busy});
      end
      checks++;
      if (mon_addr.size() != 2) begin
         errors++; $display("FAIL good_write_count: got %0d expected 2", mon_addr.size());
      end
   endtask

   task automatic test_bad_checksum();
      mon_addr.delete(); mon_word.delete();
      send_byte(8'hA5);
      checks++;
      if ({out_core_run, out_words_loaded} !== 13'h0) begin
         errors++;
         $display("FAIL hdr_clears_run: got run=%b loaded=%0d expected run=0 loaded=0", out_core_run, out_words_loaded);
      end
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h41);
      checks++;
      if ({out_core_run, out_error, out_busy} !== 3'b010) begin
         errors++;
         $display("FAIL bad_chk: got run/err/busy=%b expected 010", {out_core_run, out_error, out_busy});
      end
      checks++;
      if (mon_addr.size() != 2) begin
         errors++; $display("FAIL bad_chk_writes: got %0d expected 2", mon_addr.size());
      end
      send_byte(8'hA5);
      checks++;
      if (out_error !== 1'b0) begin
         errors++; $display("FAIL hdr_clears_error: got %b expected 0", out_error);
      end
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h42);
      checks++;
      if ({out_core_run, out_error} !== 2'b10) begin
         errors++;
         $display("FAIL recover_good: got run/err=%b expected 10", {out_core_run, out_error});
      end
   endtask

   task automatic test_len_overflow();
      mon_addr.delete(); mon_word.delete();
      send_byte(8'hA5); send_byte(8'h08); send_byte(8'h01);
      checks++;
      if ({out_error, out_busy, out_core_run, out_words_loaded} !== {3'b100, 12'd0}) begin
         errors++;
         $display("FAIL len_overflow: got err/busy/run=%b loaded=%0d expected 100 loaded=0",
                  {out_error, out_busy, out_core_run}, out_words_loaded);
      end
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      checks++;
      if ({out_error, out_busy} !== 2'b10) begin
         errors++;
         $display("FAIL trailing_dropped: got err/busy=%b expected 10", {out_error, out_busy});
      end
      checks++;
      if (mon_addr.size() != 0) begin
         errors++; $display("FAIL overflow_writes: got %0d expected 0", mon_addr.size());
      end
   endtask

   task automatic test_leading_junk();
      do_reset();
      mon_addr.delete(); mon_word.delete();
      send_byte(8'h00); send_byte(8'hFF);
      checks++;
      if (out_busy !== 1'b0) begin
         errors++; $display("FAIL junk_ignored: got busy=%b expected 0", out_busy);
      end
      send_byte(8'hA5);
      checks++;
      if (out_busy !== 1'b1) begin
         errors++; $display("FAIL hdr_after_junk: got busy=%b expected 1", out_busy);
      end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      checks++;
      if ({out_core_run, out_error, out_busy, out_words_loaded} !== {3'b100, 12'd0}) begin
         errors++;
         $display("FAIL empty_frame: got run/err/busy=%b loaded=%0d expected 100 loaded=0",
                  {out_core_run, out_error, out_busy}, out_words_loaded);
      end
      checks++;
      if (mon_addr.size() != 0) begin
         errors++; $display("FAIL empty_writes: got %0d expected 0", mon_addr.size());
      end
   endtask

   task automatic test_reset_abort();
      mon_addr.delete(); mon_word.delete();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      checks++;
      if (mon_addr.size() != 1 || out_words_loaded !== 12'd1) begin
         errors++;
         $display("FAIL pre_abort: got writes=%0d loaded=%0d expected 1 and 1", mon_addr.size(), out_words_loaded);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({out_byte_ready, out_pmem_write_en, out_busy, out_core_run, out_error} !== 5'b0 ||
          {out_pmem_addr, out_pmem_word, out_words_loaded} !== 40'h0) begin
         errors++;
         $display("FAIL async_abort: got flags=%b data=%h expected all 0",
                  {out_byte_ready, out_pmem_write_en, out_busy, out_core_run, out_error},
                  {out_pmem_addr, out_pmem_word, out_words_loaded});
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      mon_addr.delete(); mon_word.delete();
      // A5 00 01 55 66, checksum 01^55^66 = 0x32
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
      checks++;
      if ({out_pmem_write_en, out_pmem_addr, out_pmem_word} !== {1'b1, 12'h000, 16'h5566}) begin
         errors++;
         $display("FAIL restart_write: got we=%b addr=%h word=%h expected we=1 addr=000 word=5566",
                  out_pmem_write_en, out_pmem_addr, out_pmem_word);
      end
      send_byte(8'h32);
      checks++;
      if ({out_core_run, out_error} !== 2'b10) begin
         errors++; $display("FAIL restart_run: got run/err=%b expected 10", {out_core_run, out_error});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  chk;
      logic [15:0] w;
      int          bad;
      mon_addr.delete(); mon_word.delete();
      stream.delete();
      stream.push_back(8'hA5); stream.push_back(8'h08); stream.push_back(8'h00);
      chk = 8'h08;
      for (int i = 0; i < 2048; i++) begin
         w = 16'(i) ^ 16'hC3A5;
         stream.push_back(w[15:8]);
         stream.push_back(w[7:0]);
         chk = chk ^ w[15:8] ^ w[7:0];
      end
      foreach (stream[i]) send_byte(stream[i]);
      checks++;
      if ({out_core_run, out_busy} !== 2'b01) begin
         errors++;
         $display("FAIL run_before_last_chk: got run/busy=%b expected 01", {out_core_run, out_busy});
      end
      send_byte(chk);
      checks++;
      if ({out_core_run, out_error} !== 2'b10) begin
         errors++; $display("FAIL run_after_last_chk: got run/err=%b expected 10", {out_core_run, out_error});
      end
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (mon_addr.size() != 2048 || out_words_loaded !== 12'h800) begin
         errors++;
         $display("FAIL full_count: got writes=%0d loaded=%h expected 2048 loaded=800",
                  mon_addr.size(), out_words_loaded);
      end
      bad = 0;
      for (int i = 0; i < mon_addr.size() && i < 2048; i++) begin
         w = 16'(i) ^ 16'hC3A5;
         if (mon_addr[i] !== 12'(i * 2) || mon_word[i] !== w) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL full_contents: got %0d bad words expected 0", bad);
      end
      checks++;
      if (mon_addr.size() == 0 || mon_addr[mon_addr.size()-1] !== 12'hFFE) begin
         errors++;
         $display("FAIL last_addr: got %h expected ffe",
                  (mon_addr.size() == 0) ? 12'h000 : mon_addr[mon_addr.size()-1]);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_len_overflow();
      test_leading_junk();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
